// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: sequencer states, access owner, perf counter width.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_LS
    } owner_t;

    localparam int PERF_CNT_W = 16;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Core-side (IF, LS) and memory-side signal bundle of mem_port_arbiter.
// slave = arbiter view; master = core plus memory view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 19
);
    logic              IF_REQ;
    logic [ADDR_W-1:0] IF_ADDR;
    logic              IF_GNT;
    logic [DATA_W-1:0] IF_RDATA;
    logic              IF_VALID;

    logic              LS_REQ;
    logic              LS_WE;
    logic [ADDR_W-1:0] LS_ADDR;
    logic [DATA_W-1:0] LS_WDATA;
    logic              LS_GNT;
    logic [DATA_W-1:0] LS_RDATA;
    logic              LS_VALID;

    logic              MEM_WR_EN;
    logic [ADDR_W-1:0] MEM_ADDR;
    logic [DATA_W-1:0] MEM_WR_DATA;
    logic [DATA_W-1:0] MEM_RD_DATA;

    modport slave (
        input  IF_REQ, IF_ADDR, LS_REQ, LS_WE, LS_ADDR, LS_WDATA, MEM_RD_DATA,
        output IF_GNT, IF_RDATA, IF_VALID, LS_GNT, LS_RDATA, LS_VALID,
               MEM_WR_EN, MEM_ADDR, MEM_WR_DATA
    );

    modport master (
        output IF_REQ, IF_ADDR, LS_REQ, LS_WE, LS_ADDR, LS_WDATA, MEM_RD_DATA,
        input  IF_GNT, IF_RDATA, IF_VALID, LS_GNT, LS_RDATA, LS_VALID,
               MEM_WR_EN, MEM_ADDR, MEM_WR_DATA
    );

endinterface

// File: rtl/mem_arb_select.sv
// Winner selection (LS over IF) with a saturating LS-streak counter that lets IF in after STARVE_MAX LS grants.
// Combinational select, one register; only grants while arb_en is high.
module mem_arb_select #(
    parameter int STARVE_MAX = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic arb_en,
    input  logic if_req,
    input  logic ls_req,
    output logic win_if,
    output logic win_ls
);
    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STREAK_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] streak;

    always_comb begin
        win_ls = arb_en && ls_req && !(if_req && (streak == STREAK_MAX));
        win_if = arb_en && if_req && !win_ls;
    end

    // Streak only grows while IF is actually waiting; an uncontested LS grant restarts it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            streak <= '0;
        end else if (win_if) begin
            streak <= '0;
        end else if (win_ls) begin
            if (!if_req)
                streak <= '0;
            else if (streak != STREAK_MAX)
                streak <= streak + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one registered memory port between IF and LS: GNT 1 cycle after REQ, VALID 3 cycles after, 1 access / 2 cycles sustained.
// Requesters hold REQ until GNT; one access in flight. MEM_ARB_PERF_CNT_EN adds grant/stall counters.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 19,
    parameter int STARVE_MAX = 4
) (
    input  logic CLK,
    input  logic RST,
    mem_port_arbiter_if.slave bus
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    output logic [PERF_CNT_W-1:0] IF_GNT_CNT,
    output logic [PERF_CNT_W-1:0] LS_GNT_CNT,
    output logic [PERF_CNT_W-1:0] IF_STALL_CNT
`endif
);
    arb_state_t state, state_nxt;
    owner_t     owner;
    logic       acc_we;
    logic       arb_en, win_if, win_ls;
    logic       resp_if, resp_ls;

    assign arb_en  = (state == IDLE) || (state == RESP);
    assign resp_if = (state == RESP) && (owner == OWN_IF);
    assign resp_ls = (state == RESP) && (owner == OWN_LS);

    mem_arb_select #(.STARVE_MAX(STARVE_MAX)) u_select (
        .CLK    (CLK),
        .RST    (RST),
        .arb_en (arb_en),
        .if_req (bus.IF_REQ),
        .ls_req (bus.LS_REQ),
        .win_if (win_if),
        .win_ls (win_ls)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, RESP: state_nxt = (win_if || win_ls) ? ACCESS : IDLE;
            ACCESS:     state_nxt = RESP;
            default:    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.IF_GNT = 1'b0;
        bus.LS_GNT = 1'b0;
        if (state == ACCESS) begin
            bus.IF_GNT = (owner == OWN_IF);
            bus.LS_GNT = (owner == OWN_LS);
        end
    end

    // Command is captured at grant and held through ACCESS; write enable is dropped as ACCESS ends
    // so the memory reads (and does not re-write) on the RESP edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            owner           <= OWN_NONE;
            acc_we          <= 1'b0;
            bus.MEM_WR_EN   <= 1'b0;
            bus.MEM_ADDR    <= {ADDR_W{1'b0}};
            bus.MEM_WR_DATA <= {DATA_W{1'b0}};
        end else if (win_ls) begin
            owner           <= OWN_LS;
            acc_we          <= bus.LS_WE;
            bus.MEM_WR_EN   <= bus.LS_WE;
            bus.MEM_ADDR    <= bus.LS_ADDR;
            bus.MEM_WR_DATA <= bus.LS_WDATA;
        end else if (win_if) begin
            owner           <= OWN_IF;
            acc_we          <= 1'b0;
            bus.MEM_WR_EN   <= 1'b0;
            bus.MEM_ADDR    <= bus.IF_ADDR;
            bus.MEM_WR_DATA <= {DATA_W{1'b0}};
        end else if (state == ACCESS) begin
            bus.MEM_WR_EN   <= 1'b0;
        end else if (arb_en) begin
            owner           <= OWN_NONE;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bus.IF_VALID <= 1'b0;
            bus.LS_VALID <= 1'b0;
            bus.IF_RDATA <= {DATA_W{1'b0}};
            bus.LS_RDATA <= {DATA_W{1'b0}};
        end else begin
            bus.IF_VALID <= resp_if;
            bus.LS_VALID <= resp_ls;
            if (resp_if)
                bus.IF_RDATA <= bus.MEM_RD_DATA;
            if (resp_ls && !acc_we)
                bus.LS_RDATA <= bus.MEM_RD_DATA;
        end
    end

`ifdef MEM_ARB_PERF_CNT_EN
    localparam logic [PERF_CNT_W-1:0] CNT_SAT = '1;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            IF_GNT_CNT   <= '0;
            LS_GNT_CNT   <= '0;
            IF_STALL_CNT <= '0;
        end else begin
            if (win_if && (IF_GNT_CNT != CNT_SAT))
                IF_GNT_CNT <= IF_GNT_CNT + PERF_CNT_W'(1);
            if (win_ls && (LS_GNT_CNT != CNT_SAT))
                LS_GNT_CNT <= LS_GNT_CNT + PERF_CNT_W'(1);
            if (bus.IF_REQ && !bus.IF_GNT && (IF_STALL_CNT != CNT_SAT))
                IF_STALL_CNT <= IF_STALL_CNT + PERF_CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboarded bench for mem_port_arbiter: memory model, per-requester expected-data queues, grant-order queue.
module tb_mem_port_arbiter;
    localparam int AW = 12;
    localparam int DW = 19;

    typedef struct {
        logic          we;
        logic [DW-1:0] data;
    } ls_exp_t;

    logic CLK = 1'b0;
    logic RST;
    int   cyc = 0;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

`ifdef MEM_ARB_PERF_CNT_EN
    logic [15:0] if_gnt_cnt, ls_gnt_cnt, if_stall_cnt;
`endif

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(4)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
`ifdef MEM_ARB_PERF_CNT_EN
        ,
        .IF_GNT_CNT   (if_gnt_cnt),
        .LS_GNT_CNT   (ls_gnt_cnt),
        .IF_STALL_CNT (if_stall_cnt)
`endif
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    logic [DW-1:0] mem     [4096];
    logic [DW-1:0] ref_mem [4096];

    always @(posedge CLK) begin
        if (bus.MEM_WR_EN) mem[bus.MEM_ADDR] = bus.MEM_WR_DATA;
        else               bus.MEM_RD_DATA <= mem[bus.MEM_ADDR];
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [DW-1:0] if_q[$];
    ls_exp_t       ls_q[$];
    int            order_q[$];
    bit            order_en = 0;
    int            if_valid_cyc, ls_valid_seen = 0;
    int            if_gnt_tally, ls_gnt_tally, stall_tally;
    ls_exp_t       mon_e;

    always @(negedge CLK) begin
        if (RST) begin
            if_gnt_tally = 0;
            ls_gnt_tally = 0;
        end else begin
            if (bus.IF_VALID) begin
                if_valid_cyc = cyc;
                check("if_valid_expected", if_q.size() != 0, 1);
                if (if_q.size() != 0) check("if_rdata", bus.IF_RDATA, if_q.pop_front());
            end
            if (bus.LS_VALID) begin
                ls_valid_seen++;
                check("ls_valid_expected", ls_q.size() != 0, 1);
                if (ls_q.size() != 0) begin
                    mon_e = ls_q.pop_front();
                    if (!mon_e.we) check("ls_rdata", bus.LS_RDATA, mon_e.data);
                end
            end
            if (bus.IF_GNT || bus.LS_GNT) begin
                check("gnt_exclusive", bus.IF_GNT && bus.LS_GNT, 0);
                if (bus.IF_GNT) if_gnt_tally++;
                if (bus.LS_GNT) ls_gnt_tally++;
            end
            if (bus.MEM_WR_EN) check("wr_en_outside_ls_access", !bus.LS_GNT, 0);
            if (order_en && (bus.IF_GNT || bus.LS_GNT)) begin
                check("gnt_order_expected", order_q.size() != 0, 1);
                if (order_q.size() != 0) check("gnt_order", bus.LS_GNT ? 2 : 1, order_q.pop_front());
            end
        end
    end

    always @(posedge CLK) begin
        if (RST) stall_tally <= 0;
        else if (bus.IF_REQ && !bus.IF_GNT) stall_tally <= stall_tally + 1;
    end

    logic [AW-1:0] seq_addr[8];
    logic          seq_we[8];
    logic [DW-1:0] seq_wd[8];
    int            seq_gnt_cyc[8];
    int            if_gnt_cyc;

    task automatic if_op(input logic [AW-1:0] a);
        bit got = 0;
        bus.IF_REQ  = 1'b1;
        bus.IF_ADDR = a;
        if_q.push_back(ref_mem[a]);
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge CLK); #1;
            got = bus.IF_GNT;
        end
        check("if_gnt_seen", got, 1);
        if_gnt_cyc = cyc;
        check("if_mem_addr", bus.MEM_ADDR, a);
        check("if_mem_wr_en", bus.MEM_WR_EN, 0);
        check("if_mem_wr_data", bus.MEM_WR_DATA, 0);
        bus.IF_REQ = 1'b0;
    endtask

    // Holds LS_REQ across the whole sequence so each op is picked up in RESP of the previous one.
    task automatic ls_seq(input int n);
        for (int i = 0; i < n; i++) begin
            bit got = 0;
            bus.LS_REQ   = 1'b1;
            bus.LS_ADDR  = seq_addr[i];
            bus.LS_WE    = seq_we[i];
            bus.LS_WDATA = seq_wd[i];
            if (seq_we[i]) begin
                ref_mem[seq_addr[i]] = seq_wd[i];
                ls_q.push_back('{we: 1'b1, data: seq_wd[i]});
            end else begin
                ls_q.push_back('{we: 1'b0, data: ref_mem[seq_addr[i]]});
            end
            for (int k = 0; k < 40 && !got; k++) begin
                @(negedge CLK); #1;
                got = bus.LS_GNT;
            end
            check("ls_gnt_seen", got, 1);
            seq_gnt_cyc[i] = cyc;
            check("ls_mem_addr", bus.MEM_ADDR, seq_addr[i]);
            check("ls_mem_wr_en", bus.MEM_WR_EN, seq_we[i]);
            check("ls_mem_wr_data", bus.MEM_WR_DATA, seq_wd[i]);
        end
        bus.LS_REQ = 1'b0;
        bus.LS_WE  = 1'b0;
    endtask

    task automatic wait_drain();
        bit done = 0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge CLK); #1;
            done = (if_q.size() == 0) && (ls_q.size() == 0);
        end
        check("drain", done, 1);
        if_q.delete();
        ls_q.delete();
        @(negedge CLK); #1;
    endtask

    task automatic set_load(input int i, input logic [AW-1:0] a);
        seq_addr[i] = a;
        seq_we[i]   = 1'b0;
        seq_wd[i]   = DW'(a) ^ 19'h15A5A;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, vcyc, v0;
        bit got;
        for (int i = 0; i < 4096; i++) begin
            mem[i]     = DW'(i * 7 + 3);
            ref_mem[i] = DW'(i * 7 + 3);
        end
        mem[12'h010] = 19'h1ABCD;  ref_mem[12'h010] = 19'h1ABCD;
        RST = 1'b1;
        bus.IF_REQ = 0; bus.IF_ADDR = 0;
        bus.LS_REQ = 0; bus.LS_WE = 0; bus.LS_ADDR = 0; bus.LS_WDATA = 0;
        repeat (2) @(negedge CLK);
        #1;
        check("rst_if_gnt", bus.IF_GNT, 0);
        check("rst_ls_gnt", bus.LS_GNT, 0);
        check("rst_valids", {bus.IF_VALID, bus.LS_VALID}, 0);
        check("rst_mem_cmd", {bus.MEM_WR_EN, bus.MEM_ADDR, bus.MEM_WR_DATA}, 0);
        check("rst_rdata", {bus.IF_RDATA, bus.LS_RDATA}, 0);
        RST = 1'b0;
        @(negedge CLK); #1;

        // single IF read: GNT at cycle 1, VALID at cycle 3
        c0 = cyc;
        if_op(12'h010);
        check("if_gnt_latency", if_gnt_cyc - c0, 1);
        wait_drain();
        check("if_valid_latency", if_valid_cyc - c0, 3);
        check("if_rdata_1abcd", bus.IF_RDATA, 19'h1ABCD);

        // LS store then load of the same address, back-to-back
        seq_addr[0] = 12'h0FF; seq_we[0] = 1'b1; seq_wd[0] = 19'h00042;
        set_load(1, 12'h0FF);
        ls_seq(2);
        wait_drain();
        check("ls_rdata_00042", bus.LS_RDATA, 19'h00042);

        // sustained LS loads: one grant every 2 cycles
        set_load(0, 12'h020); set_load(1, 12'h021); set_load(2, 12'h022);
        ls_seq(3);
        check("spacing_0_1", seq_gnt_cyc[1] - seq_gnt_cyc[0], 2);
        check("spacing_1_2", seq_gnt_cyc[2] - seq_gnt_cyc[1], 2);
        wait_drain();

        // re-request in the VALID cycle: next GNT the cycle right after VALID
        set_load(0, 12'h123);
        ls_seq(1);
        got = 0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge CLK); #1;
            got = bus.LS_VALID;
        end
        check("ls_valid_seen", got, 1);
        vcyc = cyc;
        set_load(0, 12'h124);
        ls_seq(1);
        check("rereq_gnt_gap", seq_gnt_cyc[0] - vcyc, 1);
        wait_drain();

        // IF starvation limit: 4 LS grants, then IF, then LS
        order_en = 1;
        order_q = '{2, 2, 2, 2, 1, 2};
        for (int i = 0; i < 5; i++) set_load(i, 12'(12'h200 + i));
        fork
            ls_seq(5);
            if_op(12'h300);
        join
        wait_drain();
        check("starve_order_consumed", order_q.size(), 0);

        // streak cleared by the IF grant: LS wins a fresh contest
        order_q = '{2, 1};
        set_load(0, 12'h210);
        fork
            ls_seq(1);
            if_op(12'h301);
        join
        wait_drain();
        check("clear_order_consumed", order_q.size(), 0);
        order_en = 0;

        // reset during a store's ACCESS: write dropped, no VALID
        bus.LS_REQ = 1'b1; bus.LS_WE = 1'b1; bus.LS_ADDR = 12'h0AA; bus.LS_WDATA = 19'h07777;
        got = 0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge CLK); #1;
            got = bus.LS_GNT;
        end
        check("rst_store_gnt", got, 1);
        check("rst_store_wr_en_pre", bus.MEM_WR_EN, 1);
        RST = 1'b1;
        #1;
        check("rst_async_wr_en", bus.MEM_WR_EN, 0);
        check("rst_async_gnt", bus.LS_GNT, 0);
        check("rst_async_cmd", {bus.MEM_ADDR, bus.MEM_WR_DATA}, 0);
        check("rst_async_rdata", {bus.IF_RDATA, bus.LS_RDATA}, 0);
        bus.LS_REQ = 1'b0; bus.LS_WE = 1'b0;
        v0 = ls_valid_seen;
        repeat (2) @(negedge CLK);
        #1;
        RST = 1'b0;
        repeat (4) @(negedge CLK);
        #1;
        check("rst_no_valid", ls_valid_seen - v0, 0);
        c0 = cyc;
        if_op(12'h0AA);
        check("post_rst_gnt_latency", if_gnt_cyc - c0, 1);
        wait_drain();
        if_op(12'h0FF);
        wait_drain();
        check("if_sees_store", bus.IF_RDATA, 19'h00042);

`ifdef MEM_ARB_PERF_CNT_EN
        check("perf_if_gnt_cnt", if_gnt_cnt, 16'(if_gnt_tally));
        check("perf_ls_gnt_cnt", ls_gnt_cnt, 16'(ls_gnt_tally));
        check("perf_if_stall_cnt", if_stall_cnt, 16'(stall_tally));
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one external memory port between the CPU's instruction-fetch (IF) requester and load/store (LS) requester.
- Sits between the core and the external memory.
- Serialises accesses through a 3-state sequencer, registers all memory-side command signals, and returns read data with a valid pulse.
- Fixed LS-over-IF priority, with an anti-starvation limit for IF.

Parameters:
- ADDR_W, 12, memory address width.
- DATA_W, 19, data width for both requesters and the memory; 38 when arbitrating data memory.
- STARVE_MAX, 4, consecutive LS grants allowed while IF is pending (legal range >= 1).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous reset, active-high.
- IF_REQ  in  1  fetch request; held until IF_GNT.
- IF_ADDR  in  ADDR_W  fetch address; stable while IF_REQ.
- IF_GNT  out  1  one-cycle grant pulse.
- IF_RDATA  out  DATA_W  fetched word; holds until next IF read.
- IF_VALID  out  1  one-cycle pulse; IF_RDATA valid.
- LS_REQ  in  1  load/store request; held until LS_GNT.
- LS_WE  in  1  1 = store, 0 = load.
- LS_ADDR  in  ADDR_W  load/store address.
- LS_WDATA  in  DATA_W  store data.
- LS_GNT  out  1  one-cycle grant pulse.
- LS_RDATA  out  DATA_W  load data; holds until next LS load.
- LS_VALID  out  1  one-cycle pulse; load data valid, or store complete.
- MEM_WR_EN  out  1  memory write enable (registered).
- MEM_ADDR  out  ADDR_W  memory address (registered).
- MEM_WR_DATA  out  DATA_W  memory write data (registered).
- MEM_RD_DATA  in  DATA_W  memory output; registered in memory, updated on the edge where MEM_WR_EN=0.

Behaviour:
- Reset (async, immediate):
  - State = IDLE.
  - All outputs 0, including MEM_WR_EN, MEM_ADDR, MEM_WR_DATA, both RDATA and both VALID.
  - Owner = none; starvation counter = 0.
  - Any in-flight access is discarded and no VALID is issued for it.
- States: IDLE, ACCESS, RESP.
- Arbitration runs only in IDLE and RESP:
  - Winner = LS if LS_REQ and not (IF_REQ and streak == STARVE_MAX); else IF if IF_REQ.
  - On the edge that leaves the arbitrating state with a winner: the winner's GNT is 1 for the next cycle, MEM_ADDR/MEM_WR_EN/MEM_WR_DATA load from the winner (IF: WR_EN=0, WR_DATA=0), owner is recorded, next state = ACCESS.
  - No request: IDLE stays IDLE; RESP goes to IDLE.
- ACCESS: command is held stable, and memory executes on this edge. On exit, MEM_WR_EN goes to 0 and next state = RESP.
- RESP: MEM_RD_DATA is valid for the owner's read. On the edge leaving RESP:
  - Owner read: owner's RDATA <= MEM_RD_DATA.
  - Owner VALID = 1 for one cycle (stores too, as completion ack).
  - Arbitration repeats (back-to-back, no IDLE bubble).
- Latency:
  - REQ seen at edge e → GNT during cycle e..e+1.
  - Memory op at edge e+1.
  - VALID high after edge e+2.
  - Sustained throughput: one access per 2 cycles.
- Requester holding rules:
  - REQ must drop on the edge after GNT is seen. GNT is high only during ACCESS, so REQ is never resampled before RESP.
  - A requester may re-request in the same cycle its VALID is high.
- Starvation counter:
  - Increments (saturating at STARVE_MAX) on each LS grant made while IF_REQ=1.
  - Clears on an IF grant, and on any LS grant while IF_REQ=0.
- Simultaneous REQ: LS wins unless the counter is at its limit.
- Address: passed through unchanged; no wrap or bounds check.

Optional Feature:
- Macro: MEM_ARB_PERF_CNT_EN.
- When defined, adds outputs IF_GNT_CNT[15:0], LS_GNT_CNT[15:0] and IF_STALL_CNT[15:0].
  - The GNT counters count grants.
  - IF_STALL_CNT counts cycles with IF_REQ=1 and IF_GNT=0.
  - All three saturate at 16'hFFFF and reset to 0.
- When undefined, these ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package mem_arb_pkg holds:
  - arb_state_t enum {IDLE, ACCESS, RESP}.
  - owner_t enum {OWN_NONE, OWN_IF, OWN_LS}.
  - Perf counter width constant (16).
- One sub-module, mem_arb_select: combinational winner selection plus the starvation counter register.

Test Plan:
- Single IF read: mem[12'h010] = 19'h1ABCD; IF_REQ at addr 010 → IF_GNT at cycle 1, IF_VALID at cycle 3, IF_RDATA = 1ABCD.
- LS store then load: store 19'h00042 @ 12'h0FF, then load 0FF → LS_VALID twice, LS_RDATA = 00042; MEM_WR_EN high only during the store's ACCESS.
- Simultaneous IF+LS reads with LS held continuously, STARVE_MAX = 4 → LS granted 4 times, 5th grant goes to IF; counter then clears.
- Back-to-back: LS_REQ re-asserted during VALID → next GNT follows VALID with no IDLE cycle; 2-cycle access spacing.
- RST asserted in ACCESS of a store → MEM_WR_EN drops immediately, no VALID, state IDLE; a new IF request completes normally.
- MEM_ARB_PERF_CNT_EN defined: 3 IF + 5 LS grants with IF blocked for 6 cycles → IF_GNT_CNT = 3, LS_GNT_CNT = 5, IF_STALL_CNT = 6.
